led_chaser: RTL and testbench
=============================

# led_chaser

Running-light pattern engine that consumes the one-cycle `tick` strobe from the tick generator and drives the LED bank. On each enabled tick it advances one step of the selected pattern: rotate left, rotate right, ping-pong bounce, or fill/drain. It sits between the tick generator and the board LED pins. It emits a `cycle_done` strobe when a pattern period completes, so a higher-level sequencer can change modes on a boundary.

## Interface
- `N`, default 8: number of LEDs. Legal range is N ≥ 2.
- `PW`, default `$clog2(N)`: width of the position counter. It is derived and must not be overridden.

Ports:
- `clk`, in, 1: system clock. This is the single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: step strobe from the tick generator, high for exactly one `clk` cycle.
- `enable`, in, 1: when 0, the pattern freezes and ticks are ignored.
- `mode`, in, 2: pattern select. 0 = ROT_L, 1 = ROT_R, 2 = BOUNCE, 3 = FILL.
- `led`, out, N: LED drive, registered. Bit 0 is the rightmost LED.
- `cycle_done`, out, 1: registered one-cycle pulse at the end of a pattern period.

## Operation
- A step occurs only on a `clk` edge where `reset`=0, `tick`=1 and `enable`=1. In every other cycle, all state holds.
- The internal state is `cur_mode` (2 bits), `pos` (PW bits), `dir` (0 = up, 1 = down) and `phase` (0 = FILL, 1 = DRAIN).
- Mode change: at a step where `mode` ≠ `cur_mode`, the block loads the start state of the new mode and does not advance. `cycle_done` stays 0 at that step.
- Start states:
  - ROT_L: `pos`=0, `led`=1.
  - ROT_R: `pos`=N-1, `led`=1<<(N-1).
  - BOUNCE: `pos`=0, `dir`=up, `led`=1.
  - FILL: `led`=0, `phase`=FILL.
- ROT_L step: `pos` goes from N-1 back to 0, otherwise `pos`+1. Then `led`=1<<`pos`. `cycle_done` pulses on the N-1→0 wrap.
- ROT_R step: `pos` goes from 0 back to N-1, otherwise `pos`-1. `cycle_done` pulses on the 0→N-1 wrap.
- BOUNCE step: the block moves `pos` by ±1 according to `dir`.
  - `dir` flips to down in the same step that `pos` reaches N-1.
  - `dir` flips to up in the same step that `pos` reaches 0. `cycle_done` pulses on that step.
  - The period is 2N-2 steps, and the end LEDs are never lit twice in a row.
- FILL step, phase FILL: `led` = {`led`[N-2:0], 1}. When the result is all ones, `phase` becomes DRAIN.
- FILL step, phase DRAIN: `led` = {`led`[N-2:0], 0}. When the result is 0, `phase` becomes FILL and `cycle_done` pulses.
- FILL period: 2N steps.
- Modes 0–2 keep `led` exactly one-hot at all times. The `pos` counter never leaves the range 0..N-1, including when N is not a power of two.
- If `mode` changes while `enable`=0, the change is applied at the first enabled tick.

## Timing
- Reset values:
  - `led`=1 (LED 0 lit), `cycle_done`=0.
  - `cur_mode`=ROT_L, `pos`=0, `dir`=up, `phase`=FILL.
- `reset` has priority over `tick`, `enable` and `mode` in the same cycle.
- Reset in the middle of a pattern returns to the reset values at the next edge, regardless of mode.
- Latency: on a stepping edge, the new `led` value is visible in the following cycle. `cycle_done` is high in that same cycle, for exactly one cycle.
- `tick` held high for K consecutive cycles counts as K steps. The block does not detect edges on `tick`.
- `mode` and `enable` are sampled only on stepping edges. No synchronizer is included; both are assumed to be synchronous to `clk`.

## Structure
- Package `led_chaser_pkg` holds:
  - the mode constants `MODE_ROT_L`, `MODE_ROT_R`, `MODE_BOUNCE`, `MODE_FILL`;
  - the `dir` and `phase` encodings.
- One sub-module, `led_onehot_decode`, converts `pos` to the one-hot N-bit value, with parameter N. It is used for modes 0–2. The FILL shift register lives in `led_chaser` itself.
- Top-level wiring: the tick generator output drives `tick`. Its period parameter sets the step rate, and `led_chaser` is agnostic to that rate.

## Test plan
- Reset, then ROT_L with `enable`=1 for 9 ticks (N=8): `led` = 0x02, 0x04, …, 0x80, 0x01. `cycle_done` pulses once, on the 0x80→0x01 step.
- `mode`=1, 9 ticks: the first tick loads 0x80 with `cycle_done`=0. The following ticks give 0x40 … 0x01, then 0x80, with `cycle_done` pulsing on the wrap.
- `mode`=2, 15 ticks: the first tick loads 0x01. The next 14 ticks give 0x02 … 0x80, 0x40 … 0x01. `cycle_done` pulses only on the final return to 0x01.
- `mode`=3, 17 ticks: the first tick loads 0x00. The next 16 ticks give 0x01, 0x03, …, 0xFF, 0xFE, 0xFC, …, 0x00, with `cycle_done` on the 0x00 step.
- Hold checks:
  - `enable`=0 for 20 ticks: `led` holds.
  - `tick`=0 with `enable`=1: `led` holds.
- Reset priority: assert `reset` together with `tick` while in BOUNCE at 0x20 going down. The next cycle shows `led`=0x01, `cycle_done`=0, and the next tick gives 0x02 (ROT_L if `mode`=0).
- Sweep N=5 in BOUNCE: the period is 8 steps, `pos` never exceeds 4, and `led` stays one-hot.

Source files
------------

// File: rtl/led_chaser_pkg.sv
// Shared encodings for the LED running-light engine.
package led_chaser_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef enum logic {
        PHASE_FILL  = 1'b0,
        PHASE_DRAIN = 1'b1
    } phase_t;

endpackage

// File: rtl/led_onehot_decode.sv
// Position-to-one-hot decoder used by the single-dot patterns.
module led_onehot_decode #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [PW-1:0] pos,
    output logic [N-1:0]  onehot
);

    // Compare against every legal position so out-of-range codes light nothing.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (pos == PW'(i));
        end
    end

endmodule

// File: rtl/led_chaser.sv
// Running-light pattern engine: steps one pattern position per enabled tick
// and flags the end of each pattern period on cycle_done.
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         enable,
    input  logic [1:0]   mode,
    output logic [N-1:0] led,
    output logic         cycle_done
);

    localparam logic [PW-1:0] POS_LAST = PW'(N - 1);

    logic [1:0]    cur_mode, cur_mode_n;
    logic [PW-1:0] pos, pos_n;
    dir_t          dir, dir_n;
    phase_t        phase, phase_n;
    logic [N-1:0]  led_n;
    logic          done_n;
    logic [N-1:0]  dot;
    logic          step;
    logic          mode_load;

    assign step      = tick & enable;
    assign mode_load = step && (mode != cur_mode);

    led_onehot_decode #(.N(N), .PW(PW)) u_decode (
        .pos    (pos_n),
        .onehot (dot)
    );

    // Next position, direction, phase and period strobe for the current step.
    always_comb begin
        cur_mode_n = cur_mode;
        pos_n      = pos;
        dir_n      = dir;
        phase_n    = phase;
        done_n     = 1'b0;
        if (mode_load) begin
            // A mode switch only loads the start state; it never advances.
            cur_mode_n = mode;
            pos_n      = (mode == MODE_ROT_R) ? POS_LAST : '0;
            dir_n      = DIR_UP;
            phase_n    = PHASE_FILL;
        end else if (step) begin
            case (cur_mode)
                MODE_ROT_L: begin
                    if (pos >= POS_LAST) begin
                        pos_n  = '0;
                        done_n = 1'b1;
                    end else begin
                        pos_n = pos + PW'(1);
                    end
                end
                MODE_ROT_R: begin
                    if (pos == '0) begin
                        pos_n  = POS_LAST;
                        done_n = 1'b1;
                    end else begin
                        pos_n = pos - PW'(1);
                    end
                end
                MODE_BOUNCE: begin
                    // Direction flips on arrival at an end, so the end LED is
                    // lit once and the next step already heads back.
                    if (dir == DIR_UP && pos < POS_LAST) begin
                        pos_n = pos + PW'(1);
                        if (pos_n == POS_LAST) dir_n = DIR_DOWN;
                    end else if (pos != '0) begin
                        pos_n = pos - PW'(1);
                        dir_n = DIR_DOWN;
                        if (pos_n == '0) begin
                            dir_n  = DIR_UP;
                            done_n = 1'b1;
                        end
                    end else begin
                        pos_n = PW'(1);
                        dir_n = DIR_UP;
                    end
                end
                default: begin
                    if (phase == PHASE_FILL) begin
                        if (&{led[N-2:0], 1'b1}) phase_n = PHASE_DRAIN;
                    end else begin
                        if ({led[N-2:0], 1'b0} == '0) begin
                            phase_n = PHASE_FILL;
                            done_n  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // LED image: shift register in FILL mode, decoded dot otherwise.
    always_comb begin
        led_n = led;
        if (step) begin
            if (cur_mode_n != MODE_FILL) begin
                led_n = dot;
            end else if (mode_load) begin
                led_n = '0;
            end else if (phase == PHASE_FILL) begin
                led_n = {led[N-2:0], 1'b1};
            end else begin
                led_n = {led[N-2:0], 1'b0};
            end
        end
    end

    // State and output registers; reset overrides any step in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_mode   <= MODE_ROT_L;
            pos        <= '0;
            dir        <= DIR_UP;
            phase      <= PHASE_FILL;
            led        <= N'(1);
            cycle_done <= 1'b0;
        end else begin
            cur_mode   <= cur_mode_n;
            pos        <= pos_n;
            dir        <= dir_n;
            phase      <= phase_n;
            led        <= led_n;
            cycle_done <= done_n;
        end
    end

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: N=8 pattern walks plus an N=5 bounce sweep.
module tb_led_chaser;

    logic       clk = 1'b0;
    logic       reset, tick, enable;
    logic [1:0] mode;
    logic [7:0] led;
    logic       cycle_done;

    logic       reset5, tick5, enable5;
    logic [1:0] mode5;
    logic [4:0] led5;
    logic       done5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_chaser #(.N(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable),
        .mode(mode), .led(led), .cycle_done(cycle_done)
    );

    led_chaser #(.N(5)) dut5 (
        .clk(clk), .reset(reset5), .tick(tick5), .enable(enable5),
        .mode(mode5), .led(led5), .cycle_done(done5)
    );

    // One-cycle tick; returns at the following falling edge, where outputs are sampled.
    task automatic pulse();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic pulse5();
        @(negedge clk); tick5 = 1'b1;
        @(negedge clk); tick5 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b1; reset5 = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0; reset5 = 1'b0;
        n_cmp++;
        if (led !== 8'h01) begin n_bad++; $display("FAIL reset_led got=%h exp=%h", led, 8'h01); end
        n_cmp++;
        if (cycle_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", cycle_done); end
        n_cmp++;
        if (led5 !== 5'h01) begin n_bad++; $display("FAIL reset5_led got=%h exp=01", led5); end
    endtask

    task automatic test_rot_l();
        logic [7:0] exp [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        enable = 1'b1; mode = 2'd0;
        for (int i = 0; i < 9; i++) begin
            pulse();
            n_cmp++;
            if (led !== exp[i]) begin n_bad++; $display("FAIL rot_l_led[%0d] got=%h exp=%h", i, led, exp[i]); end
            n_cmp++;
            if (cycle_done !== (i == 7)) begin n_bad++; $display("FAIL rot_l_done[%0d] got=%b exp=%b", i, cycle_done, (i == 7)); end
        end
    endtask

    task automatic test_rot_r();
        logic [7:0] exp [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        mode = 2'd1;
        for (int i = 0; i < 9; i++) begin
            pulse();
            n_cmp++;
            if (led !== exp[i]) begin n_bad++; $display("FAIL rot_r_led[%0d] got=%h exp=%h", i, led, exp[i]); end
            n_cmp++;
            if (cycle_done !== (i == 8)) begin n_bad++; $display("FAIL rot_r_done[%0d] got=%b exp=%b", i, cycle_done, (i == 8)); end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        mode = 2'd2;
        for (int i = 0; i < 15; i++) begin
            pulse();
            n_cmp++;
            if (led !== exp[i]) begin n_bad++; $display("FAIL bounce_led[%0d] got=%h exp=%h", i, led, exp[i]); end
            n_cmp++;
            if (cycle_done !== (i == 14)) begin n_bad++; $display("FAIL bounce_done[%0d] got=%b exp=%b", i, cycle_done, (i == 14)); end
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp [17] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        mode = 2'd3;
        for (int i = 0; i < 17; i++) begin
            pulse();
            n_cmp++;
            if (led !== exp[i]) begin n_bad++; $display("FAIL fill_led[%0d] got=%h exp=%h", i, led, exp[i]); end
            n_cmp++;
            if (cycle_done !== (i == 16)) begin n_bad++; $display("FAIL fill_done[%0d] got=%b exp=%b", i, cycle_done, (i == 16)); end
        end
    endtask

    task automatic test_hold();
        // One fill step so the held value is not trivially zero.
        pulse();
        enable = 1'b0; mode = 2'd0;
        for (int i = 0; i < 20; i++) begin
            pulse();
            n_cmp++;
            if (led !== 8'h01) begin n_bad++; $display("FAIL hold_disabled[%0d] got=%h exp=01", i, led); end
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (led !== 8'h01) begin n_bad++; $display("FAIL hold_no_tick[%0d] got=%h exp=01", i, led); end
        end
        // Pending mode change from the disabled window lands now: ROT_L start.
        pulse();
        n_cmp++;
        if (led !== 8'h01 || cycle_done !== 1'b0) begin n_bad++; $display("FAIL deferred_mode got=%h/%b exp=01/0", led, cycle_done); end
        pulse();
        n_cmp++;
        if (led !== 8'h02) begin n_bad++; $display("FAIL deferred_step got=%h exp=02", led); end
    endtask

    task automatic test_reset_priority();
        mode = 2'd2;
        for (int i = 0; i < 10; i++) pulse();
        n_cmp++;
        if (led !== 8'h20) begin n_bad++; $display("FAIL prio_setup got=%h exp=20", led); end
        @(negedge clk); reset = 1'b1; tick = 1'b1;
        @(negedge clk); reset = 1'b0; tick = 1'b0;
        n_cmp++;
        if (led !== 8'h01) begin n_bad++; $display("FAIL prio_led got=%h exp=01", led); end
        n_cmp++;
        if (cycle_done !== 1'b0) begin n_bad++; $display("FAIL prio_done got=%b exp=0", cycle_done); end
        mode = 2'd0;
        pulse();
        n_cmp++;
        if (led !== 8'h02) begin n_bad++; $display("FAIL prio_next got=%h exp=02", led); end
    endtask

    task automatic test_bounce_n5();
        logic [4:0] exp [8] = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01};
        int dones;
        enable5 = 1'b1; mode5 = 2'd2;
        pulse5();
        n_cmp++;
        if (led5 !== 5'h01 || done5 !== 1'b0) begin n_bad++; $display("FAIL n5_load got=%h/%b exp=01/0", led5, done5); end
        for (int i = 0; i < 8; i++) begin
            pulse5();
            n_cmp++;
            if (led5 !== exp[i]) begin n_bad++; $display("FAIL n5_led[%0d] got=%h exp=%h", i, led5, exp[i]); end
            n_cmp++;
            if (done5 !== (i == 7)) begin n_bad++; $display("FAIL n5_done[%0d] got=%b exp=%b", i, done5, (i == 7)); end
        end
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            pulse5();
            if (done5 === 1'b1) dones++;
            n_cmp++;
            if (led5 !== exp[i % 8]) begin n_bad++; $display("FAIL n5_sweep[%0d] got=%h exp=%h", i, led5, exp[i % 8]); end
        end
        n_cmp++;
        if (dones !== 2) begin n_bad++; $display("FAIL n5_period_count got=%0d exp=2", dones); end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; enable = 1'b0; mode = 2'd0;
        reset5 = 1'b1; tick5 = 1'b0; enable5 = 1'b0; mode5 = 2'd0;
        test_reset();
        test_rot_l();
        test_rot_r();
        test_bounce();
        test_fill();
        test_hold();
        test_reset_priority();
        test_bounce_n5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
